// File: rtl/mem_unit.sv
// Word-addressed data memory with a wait-state access controller.
// Feeds the MDR input mux (m_data_in), takes its address from the MAR and
// write data from the MDR, and gives the control unit a busy/done handshake.
// The status outputs are registered from the controller state, so each one
// trails its state by one cycle.
module mem_unit #(
  parameter int REG_SIZE    = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1   // legal range 0..15 (4-bit counter)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                read,
  input  logic                write,
  input  logic [REG_SIZE-1:0] address,
  input  logic [REG_SIZE-1:0] mdr_output,
  output logic [REG_SIZE-1:0] m_data_in,
  output logic                mem_busy,
  output logic                mem_done,
  output logic                mem_error
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [REG_SIZE-1:0]     wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [REG_SIZE-1:0]     rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [REG_SIZE-1:0]     mem_q [DEPTH];

  logic                    addr_ok;
  logic                    access;
  logic                    mem_we;

  // Address is in range only when every bit above the implemented ones is clear.
  assign addr_ok = (address[REG_SIZE-1:ADDR_WIDTH] == '0);

  // Next-state logic: accept/reject in IDLE, count wait states, then access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((read ^ write) && addr_ok) begin
          op_wr_d = write;
          addr_d  = address[ADDR_WIDTH-1:0];
          wdata_d = mdr_output;
          cnt_d   = WAIT_INIT;
          err_d   = 1'b0;
          state_d = S_WAIT;
        end else if (read || write) begin
          // Both strobes high or out-of-range address: complete with error,
          // never touching the array or the read data register.
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Array strobes, read data capture and registered status derived from state.
  always_comb begin
    mem_we  = access && op_wr_q;
    rdata_d = rdata_q;
    if (access && !op_wr_q) begin
      rdata_d = mem_q[addr_q];
    end
    busy_d  = (state_q == S_WAIT);
    done_d  = (state_q == S_DONE);
    error_d = (state_q == S_DONE) && err_q;
  end

  // Controller state and outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Request latches: captured at acceptance, meaningful only while in WAIT.
  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Memory array (contents survive reset; write only on the access edge).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign m_data_in = rdata_q;
  assign mem_busy  = busy_q;
  assign mem_done  = done_q;
  assign mem_error = error_q;

endmodule
